// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Outputs come only from registered state, so no input reaches an output combinationally.
module pipe_stage_skid_reg #(
    parameter int             n      = 4,
    parameter logic [n-1:0]   PRESET = {n{1'b0}}
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         set,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    output logic [1:0]   occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [n-1:0] main_q, main_d;
    logic [n-1:0] skid_q, skid_d;
    logic         acc, pop;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_q;
    assign occupancy = state_q;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // set outranks flush; both outrank the handshake. clr is handled in the register.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (set) begin
            state_d = ONE;
            main_d  = PRESET;
            skid_d  = '0;
        end else if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move the state
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a queue holds the words the stage should hold.
module tb_pipe_stage_skid_reg;

    localparam int          N      = 8;
    localparam logic [N-1:0] PRE   = 8'h13;

    logic         clk = 1'b0;
    logic         clr, set, flush, in_valid, out_ready;
    logic [N-1:0] in_data;
    logic         in_ready, out_valid;
    logic [N-1:0] out_data;
    logic [1:0]   occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] exp_q[$];

    pipe_stage_skid_reg #(.n(N), .PRESET(PRE)) dut (
        .clk       (clk),
        .clr       (clr),
        .set       (set),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance past the edge, and update the queue model.
    task automatic tick(input logic v, input logic [N-1:0] d, input logic r,
                        input logic fl, input logic st, input logic cl);
        bit acc, pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = fl;
        set       = st;
        clr       = cl;
        acc = v && (exp_q.size() < 2);
        pop = r && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        if (cl) begin
            exp_q.delete();
        end else if (st) begin
            exp_q.delete();
            exp_q.push_back(PRE);
        end else if (fl) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(d);
        end
    endtask

    task automatic test_reset();
        tick(0, 8'h00, 0, 0, 0, 1);
        tick(0, 8'h00, 0, 0, 0, 1);
        tick(0, 8'h00, 0, 0, 0, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    endtask

    task automatic test_streaming();
        logic [N-1:0] words[3] = '{8'h11, 8'h22, 8'h33};
        logic [N-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            tick(1, words[i], 1, 0, 0, 0);
            exp = exp_q[0];
            n_checks++; if (out_data !== exp || exp !== words[i]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, words[i]); end
            n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
        end
        tick(0, 8'h00, 1, 0, 0, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] seen[$];
        tick(1, 8'hA1, 0, 0, 0, 0);
        n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_occ1: got %0d want 1", occupancy); end
        tick(1, 8'hA2, 0, 0, 0, 0);
        n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occ2: got %0d want 2", occupancy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        tick(1, 8'hA3, 0, 0, 0, 0);
        n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_hold_occ: got %0d want 2", occupancy); end
        n_checks++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_hold_data: got %h want %h", out_data, exp_q[0]); end
        // Release: A3 stays offered until the stage can take it
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen.push_back(out_data);
            tick(exp_q.size() < 3 && i < 2, 8'hA3, 1, 0, 0, 0);
        end
        n_checks++; if (seen.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", seen.size()); end
        else begin
            n_checks++; if (seen[0] !== 8'hA1 || seen[1] !== 8'hA2 || seen[2] !== 8'hA3) begin
                n_fail++; $display("FAIL bp_order: got %h %h %h want a1 a2 a3", seen[0], seen[1], seen[2]);
            end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        tick(1, 8'hA1, 0, 0, 0, 0);
        tick(1, 8'hA2, 0, 0, 0, 0);
        tick(1, 8'hB0, 0, 1, 0, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL flush_out_data: got %h want 00", out_data); end
        tick(0, 8'h00, 1, 0, 0, 0);
        n_checks++; if (out_valid !== 1'b0 || out_data === 8'hB0) begin n_fail++; $display("FAIL flush_no_b0: valid %b data %h want 0/not b0", out_valid, out_data); end
    endtask

    task automatic test_preset();
        tick(1, 8'h55, 1, 1, 1, 0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL preset_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 8'h13 || exp_q[0] !== 8'h13) begin n_fail++; $display("FAIL preset_data: got %h want 13", out_data); end
        n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL preset_occ: got %0d want 1", occupancy); end
        tick(1, 8'h55, 1, 1, 1, 1);
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL clr_over_set_occ: got %0d want 0", occupancy); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL clr_over_set_data: got %h want 00", out_data); end
    endtask

    task automatic test_random();
        logic         v, r;
        logic [N-1:0] d;
        int           pops = 0;
        for (int i = 0; i < 10000; i++) begin
            n_checks++; if (occupancy !== 2'(exp_q.size())) begin n_fail++; $display("FAIL rand_occ@%0d: got %0d want %0d", i, occupancy, exp_q.size()); end
            n_checks++; if (in_ready !== (occupancy != 2'd2)) begin n_fail++; $display("FAIL rand_in_ready@%0d: got %b occ %0d", i, in_ready, occupancy); end
            n_checks++; if (out_valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", i, out_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                n_checks++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL rand_data@%0d: got %h want %h", i, out_data, exp_q[0]); end
            end
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            d = 8'($urandom);
            if (r && exp_q.size() > 0) pops++;
            tick(v, d, r, 0, 0, 0);
        end
        n_checks++; if (pops < 1000) begin n_fail++; $display("FAIL rand_activity: got %0d pops want >=1000", pops); end
    endtask

    initial begin
        clr = 1'b1; set = 1'b0; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_preset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
